seq_det: RTL and testbench
==========================

SEQ_DET -- requirements
Module: seq_det

Interface
REQ-001 SHALL have parameter PATTERN, default 5'b10110: target sequence; first-received bit is the MSB.
REQ-002 SHALL have parameter CNT_W, default 8: width of the hit counter.
REQ-003 SHALL have port clk  input  1  system clock, 50 MHz; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port din  input  1  serial data bit, matching the serial output of the team's sequence generator.
REQ-006 SHALL have port din_valid  input  1  qualifies din; a bit is consumed only when din_valid=1.
REQ-007 SHALL have port cnt_clr  input  1  synchronous clear of hit_cnt.
REQ-008 SHALL have port detect  output  1  one-cycle pulse per pattern match.
REQ-009 SHALL have port hit_cnt  output  CNT_W  saturating count of matches.
REQ-010 SHALL have port Led  output  5  last five consumed bits; Led[0] is the newest.

Function
REQ-011 SHALL implement a Moore FSM with states IDLE, S1, S10, S101, S1011, HIT, where each state name is the longest matched pattern prefix.
REQ-012 SHALL use these transitions on a consumed bit (0 / 1):
- IDLE -> IDLE / S1
- S1 -> S10 / S1
- S10 -> IDLE / S101
- S101 -> S10 / S1011
- S1011 -> HIT / S1
- HIT -> IDLE / S101
REQ-013 SHALL detect overlapping matches: the trailing "10" of a match is reused as a prefix.
REQ-014 SHALL hold the state, Led and hit_cnt unchanged in any cycle with din_valid=0.
REQ-015 SHALL register detect, asserting it in the cycle after the edge on which the completing bit is consumed.
REQ-016 SHALL hold detect high for exactly one cycle per match, even if the FSM then stays in HIT because din_valid=0.
REQ-017 SHALL shift Led left on each consumed bit: Led <= {Led[3:0], din}.
REQ-018 SHALL increment hit_cnt by 1 in the same cycle detect is asserted.
REQ-019 SHALL saturate hit_cnt at 2^CNT_W-1, with no wrap-around.
REQ-020 SHALL set hit_cnt to 0 on cnt_clr=1; a match completing in the same cycle is not counted, but detect still pulses.
REQ-021 SHALL leave FSM and Led operation unaffected by cnt_clr.
REQ-022 SHALL have no combinational path from inputs to outputs.

Reset
REQ-023 SHALL, on rst=1 at a clock edge: state=IDLE, detect=0, hit_cnt=0, Led=5'b00000.
REQ-024 SHALL give rst priority over din_valid and cnt_clr.
REQ-025 SHALL make a reset mid-pattern discard the partial match; the next match requires a full five fresh bits.

Structure
REQ-026 SHALL place the state encoding type and the default PATTERN constant in the shared sequence package used by the generator.
REQ-027 SHALL be a single flat module.
REQ-028 SHALL implement the FSM next-state logic in a separate always block.
REQ-029 SHALL compare against the shared PATTERN constant rather than hardcoding the pattern.

Verification
REQ-030 SHALL cover single match: din_valid=1, bits 1,0,1,1,0 -> detect pulses once, 1 cycle after the 5th bit; hit_cnt=1; Led=5'b10110.
REQ-031 SHALL cover overlap: bits 1,0,1,1,0,1,1,0 -> two detect pulses 3 cycles apart; hit_cnt=2.
REQ-032 SHALL cover the generator stream: 32 bits of rotating 16'b0000_1101_1001_0101 sent MSB first -> exactly 2 detects, 16 cycles apart; hit_cnt=2.
REQ-033 SHALL cover valid gaps: 1,0,1,1 then din_valid=0 for 3 cycles, then 0 -> one detect, 1 cycle after the final bit; no change during the gap.
REQ-034 SHALL cover saturation and clear: 300 matches -> hit_cnt=255; then cnt_clr on a match cycle -> hit_cnt=0, detect=1.
REQ-035 SHALL cover mid-pattern reset: rst after 1,0,1,1, then 0 -> no detect; state=IDLE; Led=5'b00000 before the 0 is shifted in.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared sequence definitions used by the serial
// sequence generator and the sequence detector.
package seq_det_pkg;

  localparam int PAT_W = 5;

  localparam logic [PAT_W-1:0] SEQ_PATTERN = 5'b10110;

  // Each state encodes the length of the matched prefix
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4,
    HIT   = 3'd5
  } seq_state_t;

  // Longest pattern prefix that is a suffix of
  // (matched prefix of cur) followed by b.
  function automatic seq_state_t seq_next(
    input logic [PAT_W-1:0] pat,
    input seq_state_t       cur,
    input logic             b
  );
    logic [PAT_W-1:0] win;
    logic [PAT_W-1:0] sh;
    logic             ok;
    int               len;
    seq_state_t       nxt;
    len    = int'(cur);
    win    = '0;
    win[0] = b;
    for (int j = 1; j < PAT_W; j++) begin
      if (j <= len) begin
        sh     = pat >> (PAT_W - 1 - len + j);
        win[j] = sh[0];
      end
    end
    nxt = IDLE;
    for (int k = 1; k <= PAT_W; k++) begin
      ok = (k <= len + 1);
      for (int j = 0; j < PAT_W; j++) begin
        if (j < k) begin
          sh = pat >> (PAT_W - k + j);
          if (win[j] != sh[0]) ok = 1'b0;
        end
      end
      if (ok) nxt = seq_state_t'(3'(k));
    end
    return nxt;
  endfunction

endpackage

// File: rtl/seq_det.sv
// Serial pattern detector with overlapping match
// support, saturating hit counter and bit history.
import seq_det_pkg::*;

module seq_det #(
  parameter logic [4:0] PATTERN = SEQ_PATTERN,
  parameter int         CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             cnt_clr,
  output logic             detect,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [4:0]       Led
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic             w_hit;
  logic             r_detect;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_led;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_hit  = 1'b0;
    if (din_valid) begin
      w_next = seq_next(PATTERN, r_state, din);
      w_hit  = (w_next == HIT);
    end
  end

  // Pulse only on the consuming edge, not while parked in HIT
  always_ff @(posedge clk) begin
    if (rst) r_detect <= 1'b0;
    else     r_detect <= w_hit;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (cnt_clr)
      r_cnt <= '0;
    else if (w_hit && (r_cnt != CNT_MAX))
      r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_led <= 5'b00000;
    else if (din_valid)
      r_led <= {r_led[3:0], din};
  end

  assign detect  = r_detect;
  assign hit_cnt = r_cnt;
  assign Led     = r_led;

endmodule

// File: tb/tb_seq_det.sv
// Self-checking bench for seq_det against a
// bit-history reference model.
module tb_seq_det;

  localparam int         CNT_W = 8;
  localparam logic [4:0] PAT   = 5'b10110;
  localparam int         MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             din;
  logic             din_valid;
  logic             cnt_clr;
  logic             detect;
  logic [CNT_W-1:0] hit_cnt;
  logic [4:0]       Led;

  always #10 clk = ~clk;

  seq_det #(
    .PATTERN(PAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_valid(din_valid),
    .cnt_clr  (cnt_clr),
    .detect   (detect),
    .hit_cnt  (hit_cnt),
    .Led      (Led)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] m_hist;
  int         m_n;
  logic       m_det;
  int         m_cnt;

  // One clock: apply inputs, update model, sample 1ns after edge
  task automatic cyc(input logic r, input logic v,
                     input logic d, input logic c);
    rst       = r;
    din_valid = v;
    din       = d;
    cnt_clr   = c;
    @(posedge clk);
    if (r) begin
      m_hist = '0;
      m_n    = 0;
      m_det  = 1'b0;
      m_cnt  = 0;
    end else begin
      m_det = v && (m_n >= 4) && ({m_hist[3:0], d} == PAT);
      if (v) begin
        m_hist = {m_hist[3:0], d};
        m_n++;
      end
      if (c) m_cnt = 0;
      else if (m_det && m_cnt < MAXC) m_cnt++;
    end
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (detect !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_detect: got %b want 0", detect);
    end
    n_tests++;
    if (hit_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d want 0", hit_cnt);
    end
    n_tests++;
    if (Led !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_led: got %b want 00000", Led);
    end
  endtask

  task automatic test_single();
    logic [4:0] s;
    s = 5'b10110;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, s[4-i], 1'b0);
      n_tests++;
      if (detect !== (i == 4)) begin
        n_fail++;
        $display("FAIL single_det bit%0d: got %b want %b",
                 i, detect, (i == 4));
      end
    end
    n_tests++;
    if (hit_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL single_cnt: got %0d want 1", hit_cnt);
    end
    n_tests++;
    if (Led !== 5'b10110) begin
      n_fail++;
      $display("FAIL single_led: got %b want 10110", Led);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (detect !== 1'b0 || hit_cnt !== 8'd1) begin
        n_fail++;
        $display("FAIL single_hold%0d: got det=%b cnt=%0d want det=0 cnt=1",
                 i, detect, hit_cnt);
      end
    end
  endtask

  task automatic test_overlap();
    logic [7:0] s;
    int         p[$];
    s = 8'b10110110;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, s[7-i], 1'b0);
      if (detect === 1'b1) p.push_back(i);
      n_tests++;
      if (detect !== m_det) begin
        n_fail++;
        $display("FAIL overlap_det bit%0d: got %b want %b",
                 i, detect, m_det);
      end
    end
    n_tests++;
    if (p.size() != 2 || p[0] != 4 || p[1] - p[0] != 3) begin
      n_fail++;
      $display("FAIL overlap_pulses: got %0d pulses want 2 at bits 4,7",
               p.size());
    end
    n_tests++;
    if (hit_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL overlap_cnt: got %0d want 2", hit_cnt);
    end
  endtask

  task automatic test_generator();
    logic [15:0] g;
    int          p[$];
    g = 16'b0000_1101_1001_0101;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 1'b1, g[15-(i%16)], 1'b0);
      if (detect === 1'b1) p.push_back(i);
    end
    n_tests++;
    if (p.size() != 2 || p[1] - p[0] != 16) begin
      n_fail++;
      $display("FAIL gen_pulses: got %0d pulses want 2, 16 apart",
               p.size());
    end
    n_tests++;
    if (hit_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL gen_cnt: got %0d want 2", hit_cnt);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] s;
    s = 4'b1011;
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, s[3-i], 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'($urandom_range(1)), 1'b0);
      n_tests++;
      if (detect !== 1'b0 || Led !== 5'b01011 || hit_cnt !== '0) begin
        n_fail++;
        $display("FAIL gap_hold%0d: got det=%b led=%b cnt=%0d want 0 01011 0",
                 i, detect, Led, hit_cnt);
      end
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (detect !== 1'b1 || hit_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL gap_det: got det=%b cnt=%0d want 1 1",
               detect, hit_cnt);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (detect !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_pulse_len: got %b want 0", detect);
    end
  endtask

  task automatic test_saturation();
    logic [4:0] s;
    logic [2:0] t;
    int         np;
    s  = 5'b10110;
    t  = 3'b110;
    np = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, s[4-i], 1'b0);
      if (detect === 1'b1) np++;
    end
    for (int k = 0; k < 299; k++) begin
      for (int i = 0; i < 3; i++) begin
        cyc(1'b0, 1'b1, t[2-i], 1'b0);
        if (detect === 1'b1) np++;
      end
    end
    n_tests++;
    if (np != 300) begin
      n_fail++;
      $display("FAIL sat_pulses: got %0d want 300", np);
    end
    n_tests++;
    if (hit_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_cnt: got %0d want 255", hit_cnt);
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (hit_cnt !== '0 || detect !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_on_hit: got cnt=%0d det=%b want 0 1",
               hit_cnt, detect);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (hit_cnt !== '0 || detect !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_after: got cnt=%0d det=%b want 0 0",
               hit_cnt, detect);
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] s;
    logic [8:0] q;
    s = 4'b1011;
    q = 9'b0110_10110;
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, s[3-i], 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (Led !== 5'b00000 || detect !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_state: got led=%b det=%b want 00000 0",
               Led, detect);
    end
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 1'b1, q[8-i], 1'b0);
      n_tests++;
      if (detect !== (i == 8)) begin
        n_fail++;
        $display("FAIL midrst_det bit%0d: got %b want %b",
                 i, detect, (i == 8));
      end
    end
  endtask

  task automatic test_random();
    logic r, v, d, c;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(199) == 0);
      v = ($urandom_range(3) != 0);
      d = 1'($urandom_range(1));
      c = ($urandom_range(59) == 0);
      cyc(r, v, d, c);
      n_tests++;
      if (detect !== m_det) begin
        n_fail++;
        $display("FAIL rand_det cyc%0d: got %b want %b", i, detect, m_det);
      end
      n_tests++;
      if (hit_cnt !== CNT_W'(m_cnt)) begin
        n_fail++;
        $display("FAIL rand_cnt cyc%0d: got %0d want %0d",
                 i, hit_cnt, m_cnt);
      end
      n_tests++;
      if (Led !== m_hist) begin
        n_fail++;
        $display("FAIL rand_led cyc%0d: got %b want %b", i, Led, m_hist);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    din       = 1'b0;
    din_valid = 1'b0;
    cnt_clr   = 1'b0;
    m_hist    = '0;
    m_n       = 0;
    m_det     = 1'b0;
    m_cnt     = 0;
    test_reset();
    test_single();
    test_overlap();
    test_generator();
    test_gaps();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
